// File: rtl/uart_ctrl_pkg.sv
// Shared state encoding and defaults for the UART transmit-side controllers.
package uart_ctrl_pkg;

    localparam int DEFAULT_N_REQ         = 4;
    localparam int DEFAULT_START_TIMEOUT = 16;
    localparam int START_CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } tx_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request after last_grant wins.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    localparam int IDW  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [IDW-1:0]   winner,
    output logic             valid
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    int                 offset;
    int                 pos;

    // Rotate so bit 0 is the requester just after last_grant, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[int'(last_grant) + 1 +: N_REQ];
        valid   = |req_rot;
        offset  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = i;
        end
        pos = int'(last_grant) + 1 + offset;
        if (pos >= N_REQ) pos = pos - N_REQ;
        winner = IDW'(pos);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters, round-robin, with a start timeout.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_IDLE       | no transfer; grant when enabled, transmitter idle, any req
// ST_ISSUE      | one cycle: Tx_WR and ack[grant_id] pulse
// ST_WAIT_START | waiting for Tx_BUSY to rise; counter guards against a dead transmitter
// ST_WAIT_DONE  | byte in flight; return to idle when Tx_BUSY falls
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ         = DEFAULT_N_REQ,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    localparam int IDW          = id_width(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr,
    output logic               Tx_EN,
    output logic               Tx_WR,
    output logic [7:0]         Tx_DATA,
    input  logic               Tx_BUSY
);

    localparam logic [START_CNT_W-1:0] START_LAST = START_CNT_W'(START_TIMEOUT - 1);

    tx_state_t              state;
    logic [IDW-1:0]         last_grant;
    logic [IDW-1:0]         win_id;
    logic                   win_valid;
    logic [7:0]             win_byte;
    logic [START_CNT_W-1:0] start_cnt;
    logic [START_CNT_W-1:0] start_cnt_nxt;
    logic                   start_timeout;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .winner     (win_id),
        .valid      (win_valid)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == IDW'(i)) win_byte = req_data[8*i +: 8];
        end
    end

    // Timeout fires on the edge where the counter would reach START_TIMEOUT-1.
    assign start_cnt_nxt = start_cnt + 1'b1;
    assign start_timeout = (state == ST_WAIT_START) && !Tx_BUSY && (start_cnt_nxt == START_LAST);

    assign busy  = (state != ST_IDLE);
    assign Tx_EN = enable | busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            Tx_WR       <= 1'b0;
            ack         <= '0;
            Tx_DATA     <= 8'h00;
            grant_id    <= '0;
            last_grant  <= IDW'(N_REQ - 1);
            start_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (start_timeout) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && !Tx_BUSY && win_valid) begin
                        state    <= ST_ISSUE;
                        grant_id <= win_id;
                        Tx_DATA  <= win_byte;
                        Tx_WR    <= 1'b1;
                        ack      <= N_REQ'(1) << win_id;
                    end
                end
                ST_ISSUE: begin
                    Tx_WR     <= 1'b0;
                    ack       <= '0;
                    start_cnt <= '0;
                    state     <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    start_cnt <= start_cnt_nxt;
                    if (Tx_BUSY) begin
                        state <= ST_WAIT_DONE;
                    end else if (start_timeout) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/transmitter models plus a round-robin reference.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           err_clr;
    logic           Tx_BUSY;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;
    logic           Tx_EN;
    logic           Tx_WR;
    logic [7:0]     Tx_DATA;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [N][$];
    int         want_seq [N];
    int         done_seq [N];
    logic [7:0] want_byte [N];
    logic [N-1:0] refill = '0;
    bit         auto_gen = 0;
    bit         xmit_on = 1;
    bit         long_busy = 0;
    int         pushed = 0;
    int         rx_count = 0;
    int         order_q [$];
    int         model_last = N - 1;
    logic [7:0] last_byte = 8'h00;
    logic [N-1:0] req_hist = '0;
    logic       busy_hist = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .Tx_BUSY     (Tx_BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic send(input int i, input logic [7:0] b);
        want_byte[i] = b;
        want_seq[i]++;
    endtask

    // What the arbiter saw at each rising edge.
    always @(posedge clk) begin
        req_hist  <= req;
        busy_hist <= Tx_BUSY;
    end

    // Requesters: raise on demand, hold until ack, optionally keep requesting after ack.
    initial begin
        logic [7:0] b;
        req      = '0;
        req_data = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if (refill[i]) begin
                        exp_q[i].push_back(req_data[8*i +: 8]);
                        pushed++;
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && want_seq[i] != done_seq[i]) begin
                    req_data[8*i +: 8] = want_byte[i];
                    req[i] = 1'b1;
                    exp_q[i].push_back(want_byte[i]);
                    pushed++;
                    done_seq[i]++;
                end else if (!req[i] && auto_gen && $urandom_range(0, 3) == 0) begin
                    b = 8'($urandom);
                    req_data[8*i +: 8] = b;
                    req[i] = 1'b1;
                    exp_q[i].push_back(b);
                    pushed++;
                end
            end
        end
    end

    // Transmitter: after a write, go busy after a short delay for a few cycles.
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (xmit_on && Tx_WR && !reset) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                Tx_BUSY = 1'b1;
                repeat (long_busy ? 20 : $urandom_range(2, 6)) @(negedge clk);
                Tx_BUSY = 1'b0;
            end
        end
    end

    // Monitor / receiver: every write must be the round-robin winner's oldest byte.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_last = N - 1;
                last_byte  = 8'h00;
            end else if (Tx_WR) begin
                check("wr_while_tx_busy", busy_hist, 0);
                e = rr_pick(req_hist, model_last);
                if (e < 0) begin
                    check("wr_without_req", Tx_WR, 0);
                end else begin
                    check("grant_id", grant_id, e);
                    check("ack_onehot", ack, 32'(1) << e);
                    if (exp_q[e].size() == 0) begin
                        check("no_expected_byte", exp_q[e].size(), 1);
                    end else begin
                        last_byte = exp_q[e].pop_front();
                        check("tx_data", Tx_DATA, last_byte);
                    end
                    model_last = e;
                    order_q.push_back(e);
                    rx_count++;
                end
            end else begin
                check("ack_without_wr", ack, 0);
                check("tx_data_held", Tx_DATA, last_byte);
            end
        end
    end

    task automatic wait_wr(input int max, output bit ok);
        ok = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (Tx_WR) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_wr_timeout", 0, 1);
    endtask

    task automatic drain(input int max);
        bit done = 0;
        bit seq_idle;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            seq_idle = 1;
            for (int i = 0; i < N; i++) if (want_seq[i] != done_seq[i]) seq_idle = 0;
            if (req == '0 && !busy && !Tx_BUSY && seq_idle) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int base;
        int got;
        int rx0;

        reset   = 1'b1;
        enable  = 1'b0;
        err_clr = 1'b0;
        #1;
        check("rst_tx_en_off", Tx_EN, 0);
        enable = 1'b1;
        #1;
        check("rst_tx_en_on", Tx_EN, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_wr", Tx_WR, 0);
        check("rst_data", Tx_DATA, 8'h00);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fairness: all four held, expect 0,1,2,3,0.
        base   = order_q.size();
        refill = '1;
        for (int i = 0; i < N; i++) send(i, 8'(8'h10 + i));
        for (int k = 0; k < 300 && order_q.size() < base + 5; k++) @(negedge clk);
        refill = '0;
        drain(300);
        for (int k = 0; k < 5; k++) begin
            got = (order_q.size() > base + k) ? order_q[base + k] : -1;
            check("fair_order", got, k % N);
        end

        // Single request, one-cycle latency.
        rx0 = rx_count;
        @(negedge clk);
        send(2, 8'hA5);
        @(negedge clk);
        check("single_early_wr", Tx_WR, 0);
        @(negedge clk);
        check("single_wr", Tx_WR, 1);
        check("single_ack", ack, 4'b0100);
        check("single_data", Tx_DATA, 8'hA5);
        drain(100);
        check("single_rx_count", rx_count - rx0, 1);

        // Start timeout with a silent transmitter.
        xmit_on = 0;
        send(1, 8'h5A);
        wait_wr(20, ok);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) check("tmo_not_yet", timeout_err, 0);
        end
        check("tmo_set", timeout_err, 1);
        check("tmo_back_idle", busy, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", timeout_err, 0);
        xmit_on = 1;
        send(1, 8'h61);
        send(2, 8'h62);
        send(3, 8'h63);
        wait_wr(20, ok);
        check("after_tmo_grant", grant_id, 2);
        drain(300);

        // Timeout set beats a simultaneous clear.
        xmit_on = 0;
        err_clr = 1'b1;
        send(3, 8'hC3);
        wait_wr(20, ok);
        for (int k = 1; k <= 16; k++) @(negedge clk);
        check("tmo_vs_clr", timeout_err, 1);
        err_clr = 1'b0;
        @(negedge clk);
        check("tmo_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr_again", timeout_err, 0);
        xmit_on = 1;

        // Enable gating, and an in-flight transfer survives enable dropping.
        enable = 1'b0;
        send(0, 8'h77);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (Tx_WR) seen = 1;
        end
        check("en_gate_no_wr", seen, 0);
        check("en_gate_tx_en", Tx_EN, 0);
        enable = 1'b1;
        wait_wr(2, ok);
        enable = 1'b0;
        @(negedge clk);
        check("tx_en_in_flight", Tx_EN, 1);
        check("busy_in_flight", busy, 1);
        drain(100);
        check("tx_en_idle_off", Tx_EN, 0);
        enable = 1'b1;

        // Reset while the byte is on the wire.
        long_busy = 1;
        send(1, 8'h3C);
        wait_wr(20, ok);
        for (int k = 0; k < 20 && !Tx_BUSY; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_wr", Tx_WR, 0);
        check("rst_mid_data", Tx_DATA, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        long_busy = 0;
        send(3, 8'h33);
        send(0, 8'h30);
        wait_wr(60, ok);
        check("post_rst_grant", grant_id, 0);
        drain(200);

        // Randomized traffic with enable toggling.
        auto_gen = 1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
        end
        auto_gen = 0;
        enable   = 1'b1;
        drain(600);
        for (int i = 0; i < N; i++) check("exp_q_drained", exp_q[i].size(), 0);
        check("rx_total", rx_count, pushed);
        check("no_random_timeout", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_transmitter.
REQ-002 Parameter START_TIMEOUT, default 16: cycles allowed for Tx_BUSY to rise after a write.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  permits new grants; does not abort a transfer in progress.
REQ-006 req  input  N_REQ  per-requester byte-send request; held until the matching ack.
REQ-007 req_data  input  8*N_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i]=1.
REQ-008 ack  output  N_REQ  one-cycle pulse: byte of requester i handed to the transmitter.
REQ-009 grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 timeout_err  output  1  sticky flag: Tx_BUSY failed to rise within START_TIMEOUT.
REQ-012 err_clr  input  1  clears timeout_err; loses to a same-cycle set.
REQ-013 Tx_EN  output  1  transmitter enable.
REQ-014 Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-015 Tx_DATA  output  8  byte to the transmitter; registered.
REQ-016 Tx_BUSY  input  1  transmitter busy status.

Function
REQ-017 States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-018 IDLE -> ISSUE when enable=1, Tx_BUSY=0 and |req=1. In that cycle, register grant_id as the round-robin winner and capture its byte into Tx_DATA.
REQ-019 Round robin: search starts at last_grant+1 modulo N_REQ; last_grant resets to N_REQ-1, so req[0] wins first.
REQ-020 ISSUE lasts exactly one cycle, with Tx_WR=1 and ack[grant_id]=1; all other ack bits are 0. Next state is WAIT_START.
REQ-021 Latency: a req sampled high in IDLE produces Tx_WR and ack on the next cycle.
REQ-022 WAIT_START -> WAIT_DONE when Tx_BUSY=1. A 4-bit counter is cleared on entry and increments each cycle.
REQ-023 If the counter reaches START_TIMEOUT-1 with Tx_BUSY still 0: set timeout_err, update last_grant, and go to IDLE.
REQ-024 WAIT_DONE -> IDLE when Tx_BUSY=0; last_grant <= grant_id on that transition.
REQ-025 Tx_EN = enable OR (state != IDLE), so a transfer in flight is never cut off.
REQ-026 A req dropped after capture does not cancel the transfer; ack is still issued.
REQ-027 enable=0 in IDLE blocks new grants; pending reqs are held, not lost.
REQ-028 Tx_DATA holds its value outside ISSUE; it changes only on capture.
REQ-029 At most one Tx_WR per byte; no Tx_WR while Tx_BUSY=1 in IDLE.

Reset
REQ-030 On reset, asynchronously: state=IDLE, Tx_WR=0, ack=0, Tx_DATA=8'h00, grant_id=0, last_grant=N_REQ-1, counter=0, timeout_err=0.
REQ-031 Tx_EN and busy follow REQ-025 and REQ-010 from reset state: Tx_EN=enable, busy=0.
REQ-032 Reset mid-transfer returns to IDLE immediately; no ack or Tx_WR is issued afterwards.

Structure
REQ-033 Shared package uart_ctrl_pkg holds the state encoding, the default N_REQ and the default START_TIMEOUT.
REQ-034 Sub-module rr_arbiter (combinational: req, last_grant -> winner, valid) is instantiated once.

Verification
REQ-035 Single request: req=4'b0100, byte 8'hA5 -> Tx_WR and ack=4'b0100 one cycle later, Tx_DATA=8'hA5, exactly one byte received by the paired uart_receiver.
REQ-036 Fairness: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13 -> transmission order 0,1,2,3,0; each requester gets one ack per round.
REQ-037 Timeout: Tx_BUSY tied 0 and req[1]=1 -> timeout_err=1 16 cycles after ISSUE. Then err_clr pulse -> timeout_err=0. Next grant goes to index 2 if requested.
REQ-038 Enable gating: enable=0 with req=4'b0001 -> no Tx_WR for 100 cycles. Then enable=1 -> Tx_WR within 2 cycles.
REQ-039 Reset during WAIT_DONE -> state IDLE, busy=0 and ack=0 on the same edge. After release, the next grant goes to req[0] again.
REQ-040 Simultaneous err_clr and timeout in the same cycle -> timeout_err=1.
